// File: rtl/system_key_poller.sv
`timescale 1ns/1ps
// system_key_poller: Avalon-MM read initiator that polls a single-bit key PIO
// (address 0) every POLL_DIV idle cycles and debounces bit KEY_BIT of the
// read data into a clean level, one-cycle edge pulses and a sticky press flag.
// Ports: clk, reset (sync, active-high); avm_address/avm_read/avm_readdata/
// avm_waitrequest to the PIO s1 port; key_level, key_fall, key_rise,
// event_pending, event_clear to the application FSM.
// Option SYSTEM_KEY_POLLER_TIMEOUT_EN: adds WAIT_TIMEOUT and a sticky
// bus_error output; a read stalled WAIT_TIMEOUT cycles is abandoned.
module system_key_poller #(
   parameter int unsigned POLL_DIV     = 50000,
   parameter int unsigned DEBOUNCE_CNT = 4,
   parameter int unsigned READ_LATENCY = 1,
   parameter int unsigned KEY_BIT      = 0,
`ifdef SYSTEM_KEY_POLLER_TIMEOUT_EN
   parameter int unsigned WAIT_TIMEOUT = 256,
`endif
   parameter logic        RESET_LEVEL  = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   output logic [1:0]  avm_address,
   output logic        avm_read,
   input  logic [31:0] avm_readdata,
   input  logic        avm_waitrequest,
   output logic        key_level,
   output logic        key_fall,
   output logic        key_rise,
   output logic        event_pending,
`ifdef SYSTEM_KEY_POLLER_TIMEOUT_EN
   output logic        bus_error,
`endif
   input  logic        event_clear
);

   // One counter serves both the idle interval and the read latency.
   localparam int unsigned CNT_MAX =
      (POLL_DIV > READ_LATENCY) ? POLL_DIV : READ_LATENCY;
   localparam int unsigned CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int unsigned DW =
      (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;

   localparam logic [CW-1:0] POLL_LAST = CW'(POLL_DIV - 1);
   localparam logic [CW-1:0] LAT_LAST  = CW'(READ_LATENCY - 1);
   localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CNT - 1);
   localparam logic [4:0]    KB        = 5'(KEY_BIT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] db_cnt_q, db_cnt_d;
   logic          level_q, level_d;
   logic          fall_q, fall_d;
   logic          rise_q, rise_d;
   logic          pend_q, pend_d;
   logic          read_q, read_d;
   logic          capture;
   logic          smp;

`ifdef SYSTEM_KEY_POLLER_TIMEOUT_EN
   localparam int unsigned TW =
      (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
   localparam logic [TW-1:0] TO_LAST = TW'(WAIT_TIMEOUT - 1);

   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic          berr_q, berr_d;
`endif

   // Only bit KEY_BIT of the read data is meaningful.
   logic unused_rd;
   assign unused_rd = ^avm_readdata;
   assign smp       = avm_readdata[KB];

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      db_cnt_d = db_cnt_q;
      level_d  = level_q;
      fall_d   = 1'b0;
      rise_d   = 1'b0;
      capture  = 1'b0;
`ifdef SYSTEM_KEY_POLLER_TIMEOUT_EN
      to_cnt_d = '0;
      berr_d   = berr_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (cnt_q == POLL_LAST) begin
               state_d = S_REQ;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_REQ: begin
            if (!avm_waitrequest) begin
               state_d = S_WAIT;
               cnt_d   = '0;
            end
`ifdef SYSTEM_KEY_POLLER_TIMEOUT_EN
            else if (to_cnt_q == TO_LAST) begin
               state_d = S_IDLE;
               cnt_d   = '0;
               berr_d  = 1'b1;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
`endif
         end
         S_WAIT: begin
            if (cnt_q == LAT_LAST) begin
               capture = 1'b1;
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase

      if (capture) begin
         if (smp == level_q) begin
            db_cnt_d = '0;
         end else if (db_cnt_q == DB_LAST) begin
            level_d  = smp;
            db_cnt_d = '0;
            fall_d   = ~smp;
            rise_d   = smp;
         end else begin
            db_cnt_d = db_cnt_q + 1'b1;
         end
      end

      // A new press outranks a simultaneous clear.
      pend_d = fall_d | (pend_q & ~event_clear);
      read_d = (state_d == S_REQ);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         db_cnt_q <= '0;
         level_q  <= RESET_LEVEL;
         fall_q   <= 1'b0;
         rise_q   <= 1'b0;
         pend_q   <= 1'b0;
         read_q   <= 1'b0;
`ifdef SYSTEM_KEY_POLLER_TIMEOUT_EN
         to_cnt_q <= '0;
         berr_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         db_cnt_q <= db_cnt_d;
         level_q  <= level_d;
         fall_q   <= fall_d;
         rise_q   <= rise_d;
         pend_q   <= pend_d;
         read_q   <= read_d;
`ifdef SYSTEM_KEY_POLLER_TIMEOUT_EN
         to_cnt_q <= to_cnt_d;
         berr_q   <= berr_d;
`endif
      end
   end

   assign avm_address   = 2'b00;
   assign avm_read      = read_q;
   assign key_level     = level_q;
   assign key_fall      = fall_q;
   assign key_rise      = rise_q;
   assign event_pending = pend_q;
`ifdef SYSTEM_KEY_POLLER_TIMEOUT_EN
   assign bus_error     = berr_q;
`endif

endmodule

// File: tb/tb_system_key_poller.sv
`timescale 1ns/1ps
// tb_system_key_poller: directed scoreboard bench for system_key_poller.
// POLL_DIV=4, DEBOUNCE_CNT=3, READ_LATENCY=1 with a modelled PIO slave.
module tb_system_key_poller;

   localparam int K_READ = 0;
   localparam int K_FALL = 1;
   localparam int K_RISE = 2;

   typedef struct {
      int   kind;
      int   cyc;
      int   len;
      logic lvl;
      logic pend;
   } ev_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  avm_address;
   logic        avm_read;
   logic [31:0] rd_data = '0;
   logic        avm_waitrequest;
   logic        key_level;
   logic        key_fall;
   logic        key_rise;
   logic        event_pending;
   logic        event_clear = 1'b0;
`ifdef SYSTEM_KEY_POLLER_TIMEOUT_EN
   logic        bus_error;
`endif

   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   budget = 0;
   int   stall_done = 0;
   int   s_idx = 0;
   ev_t  exp_q[$];

   // Sample i returned by the slave for the i-th accepted read (bit 0 = s0).
   logic [21:0] samp = 22'b0000011100010011100011;

   system_key_poller #(
      .POLL_DIV(4),
      .DEBOUNCE_CNT(3),
      .READ_LATENCY(1),
      .KEY_BIT(0),
`ifdef SYSTEM_KEY_POLLER_TIMEOUT_EN
      .WAIT_TIMEOUT(8),
`endif
      .RESET_LEVEL(1'b1)
   ) dut (
      .clk(clk),
      .reset(reset),
      .avm_address(avm_address),
      .avm_read(avm_read),
      .avm_readdata(rd_data),
      .avm_waitrequest(avm_waitrequest),
      .key_level(key_level),
      .key_fall(key_fall),
      .key_rise(key_rise),
      .event_pending(event_pending),
`ifdef SYSTEM_KEY_POLLER_TIMEOUT_EN
      .bus_error(bus_error),
`endif
      .event_clear(event_clear)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (reset) cyc <= 0;
      else cyc <= cyc + 1;
   end

   assign avm_waitrequest = (stall_done < budget);

   // PIO slave: registered readdata, other bits the inverse of the key bit.
   always @(posedge clk) begin
      if (avm_read && !avm_waitrequest) begin
         if (s_idx < 22)
            rd_data <= {{31{~samp[s_idx]}}, samp[s_idx]};
         s_idx <= s_idx + 1;
      end
      if (avm_read && avm_waitrequest)
         stall_done <= stall_done + 1;
   end

   function automatic void push(input int k, input int c, input int l,
                                input logic lv, input logic pe);
      exp_q.push_back('{k, c, l, lv, pe});
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at cyc %0d: got %0h expected %0h",
                  nm, cyc, act, exp);
      end
   endtask

   task automatic emit(input int k, input int c, input int l,
                       input logic lv, input logic pe);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL event: got kind=%0d cyc=%0d len=%0d expected none",
                  k, c, l);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != k || e.cyc != c ||
             (k == K_READ && e.len != l) ||
             (k != K_READ && (e.lvl !== lv || e.pend !== pe))) begin
            failures++;
            $display("FAIL event: got kind=%0d cyc=%0d len=%0d lvl=%b pend=%b expected kind=%0d cyc=%0d len=%0d lvl=%b pend=%b",
                     k, c, l, lv, pe, e.kind, e.cyc, e.len, e.lvl, e.pend);
         end
      end
   endtask

   task automatic run_monitor();
      logic prev_rd;
      int   st;
      prev_rd = 1'b0;
      st = 0;
      forever begin
         @(negedge clk);
         if (avm_read) begin
            chk("avm_address", {30'd0, avm_address}, 32'd0);
            if (!prev_rd) st = cyc;
         end else if (prev_rd) begin
            emit(K_READ, st, cyc - st, 1'b0, 1'b0);
         end
         if (key_fall) emit(K_FALL, cyc, 0, key_level, event_pending);
         if (key_rise) emit(K_RISE, cyc, 0, key_level, event_pending);
         prev_rd = avm_read;
      end
   endtask

   task automatic wait_cyc(input int n);
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (cyc != n && k < 500);
      checks++;
      if (cyc != n) begin
         failures++;
         $display("FAIL wait_cyc: got cyc %0d expected %0d", cyc, n);
      end
   endtask

   initial begin
      fork
         run_monitor();
      join_none

      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // polls at 4+6k; pulses 2 cycles after a qualifying read
      push(K_READ, 4, 1, 1'b0, 1'b0);
      push(K_READ, 10, 1, 1'b0, 1'b0);
      push(K_READ, 16, 1, 1'b0, 1'b0);
      push(K_READ, 22, 1, 1'b0, 1'b0);
      push(K_READ, 28, 1, 1'b0, 1'b0);
      push(K_FALL, 30, 0, 1'b0, 1'b1);
      push(K_READ, 34, 1, 1'b0, 1'b0);
      push(K_READ, 40, 1, 1'b0, 1'b0);
      push(K_READ, 46, 1, 1'b0, 1'b0);
      push(K_RISE, 48, 0, 1'b1, 1'b1);
      push(K_READ, 52, 1, 1'b0, 1'b0);
      push(K_READ, 58, 1, 1'b0, 1'b0);
      push(K_READ, 64, 1, 1'b0, 1'b0);
      push(K_READ, 70, 1, 1'b0, 1'b0);
      push(K_READ, 76, 1, 1'b0, 1'b0);
      push(K_READ, 82, 1, 1'b0, 1'b0);
      push(K_FALL, 84, 0, 1'b0, 1'b1);
      push(K_READ, 88, 1, 1'b0, 1'b0);
      push(K_READ, 94, 1, 1'b0, 1'b0);
      push(K_READ, 100, 6, 1'b0, 1'b0);
      push(K_RISE, 107, 0, 1'b1, 1'b0);
      push(K_READ, 111, 1, 1'b0, 1'b0);
      push(K_READ, 117, 1, 1'b0, 1'b0);

      chk("rst_read", {31'd0, avm_read}, 32'd0);
      chk("rst_level", {31'd0, key_level}, 32'd1);
      chk("rst_fall", {31'd0, key_fall}, 32'd0);
      chk("rst_rise", {31'd0, key_rise}, 32'd0);
      chk("rst_pend", {31'd0, event_pending}, 32'd0);

      wait_cyc(29);
      chk("level_pre_fall", {31'd0, key_level}, 32'd1);
      wait_cyc(83);
      chk("level_pre_fall2", {31'd0, key_level}, 32'd1);
      event_clear = 1'b1;
      wait_cyc(85);
      event_clear = 1'b0;
      chk("pend_cleared", {31'd0, event_pending}, 32'd0);

      wait_cyc(98);
      budget = 5;

      wait_cyc(118);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rst2_read", {31'd0, avm_read}, 32'd0);
      chk("rst2_level", {31'd0, key_level}, 32'd1);
      chk("rst2_pend", {31'd0, event_pending}, 32'd0);

      push(K_READ, 4, 1, 1'b0, 1'b0);
      push(K_READ, 10, 1, 1'b0, 1'b0);
      push(K_READ, 16, 1, 1'b0, 1'b0);
      push(K_FALL, 18, 0, 1'b0, 1'b1);
      wait_cyc(19);

`ifdef SYSTEM_KEY_POLLER_TIMEOUT_EN
      budget = 1005;
      push(K_READ, 22, 8, 1'b0, 1'b0);
      wait_cyc(29);
      chk("berr_before", {31'd0, bus_error}, 32'd0);
      chk("read_stalled", {31'd0, avm_read}, 32'd1);
      wait_cyc(30);
      chk("berr_set", {31'd0, bus_error}, 32'd1);
      chk("read_dropped", {31'd0, avm_read}, 32'd0);
      wait_cyc(32);
      chk("berr_sticky", {31'd0, bus_error}, 32'd1);
`else
      wait_cyc(21);
`endif

      chk("events_left", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/system_key_poller.md
Name: system_key_poller

Overview:
Avalon-MM read initiator for the single-bit key PIO slave (registered readdata, address 0 = data register). It polls the PIO at a fixed interval and debounces the sampled bit. It then drives a clean level, one-cycle edge pulses and a sticky press event to downstream control logic. It sits between the key PIO's s1 port and the application FSM, so the processor no longer has to poll the key.

Parameters:
POLL_DIV, 50000, idle cycles between successive reads (>=1)
DEBOUNCE_CNT, 4, consecutive differing samples required to change level (>=1)
READ_LATENCY, 1, fixed slave read latency in cycles (>=1)
KEY_BIT, 0, bit of readdata that is sampled (0..31)
RESET_LEVEL, 1, reset value of key_level (keys idle high, active-low)

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
avm_address  out  2  read address, constant 2'b00
avm_read  out  1  read request
avm_readdata  in  32  slave read data
avm_waitrequest  in  1  slave stall (tie 0 if slave has none)
key_level  out  1  debounced key level
key_fall  out  1  one-cycle pulse on debounced 1->0 (press)
key_rise  out  1  one-cycle pulse on debounced 0->1 (release)
event_pending  out  1  sticky press flag
event_clear  in  1  clears event_pending

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values:
  - avm_read=0, avm_address=0.
  - key_level=RESET_LEVEL.
  - key_fall=key_rise=0, event_pending=0.
  - FSM=IDLE, all counters 0.
- IDLE:
  - cnt increments each cycle.
  - At cnt==POLL_DIV-1, next state is REQ and cnt is cleared.
- REQ:
  - avm_read=1, address held 0.
  - Read is accepted on the edge where avm_waitrequest==0.
  - On acceptance: next state is WAIT, cnt cleared.
  - While waitrequest=1: stay in REQ with read held.
- WAIT:
  - avm_read=0; lasts exactly READ_LATENCY cycles.
  - On the edge ending the last WAIT cycle (cnt==READ_LATENCY-1), capture s=avm_readdata[KEY_BIT] and go to IDLE.
- Poll period with waitrequest=0: POLL_DIV+1+READ_LATENCY cycles.
- Debounce, evaluated at the capture edge only:
  - s==key_level: db_cnt<=0.
  - s!=key_level and db_cnt==DEBOUNCE_CNT-1: key_level<=s, db_cnt<=0, and the matching pulse (key_fall if s==0, key_rise if s==1) is asserted for the next cycle only.
  - Otherwise: db_cnt<=db_cnt+1.
  - DEBOUNCE_CNT=1: level follows every sample.
- Pulses are 0 in every cycle that does not immediately follow a qualifying capture edge; at most one pulse per capture.
- event_pending:
  - Set at the same edge key_fall is generated.
  - Cleared when event_clear=1.
  - Simultaneous set and clear: set wins.
- Reset asserted mid-transaction (REQ or WAIT):
  - Read abandoned, avm_read low the next cycle, no capture.
  - Any in-flight slave data is ignored.
- Counter widths: $clog2 of the maximum count, minimum 1 bit; no wrap in normal operation.
- Bits of avm_readdata other than KEY_BIT are ignored.

Optional Feature:
Macro SYSTEM_KEY_POLLER_TIMEOUT_EN.
- Defined:
  - Adds parameter WAIT_TIMEOUT (default 256) and output port bus_error (1 bit, reset 0).
  - A counter runs while in REQ with waitrequest=1. When it reaches WAIT_TIMEOUT-1: avm_read drops the next cycle, FSM returns to IDLE, no capture, debounce state unchanged, bus_error set sticky.
  - bus_error is cleared only by reset.
- Not defined: no port, no counter; REQ waits indefinitely.

Test Plan:
1. Reset, POLL_DIV=4, READ_LATENCY=1, waitrequest=0 -> first avm_read in cycle 4 after reset release (cycles 0-3 IDLE), one cycle wide, repeating every 6 cycles; key_level=1, no pulses.
2. DEBOUNCE_CNT=3, readdata[0]=0 constant from the first poll -> key_level goes 0 after the 3rd capture; key_fall high exactly one cycle; event_pending=1; key_rise never asserts.
3. DEBOUNCE_CNT=3, sample pattern 0,0,1,0,0,0 -> no change after the first two (the 1 resets db_cnt); key_level=0 only after the 6th capture; one key_fall.
4. waitrequest=1 for 5 cycles during REQ -> avm_read held 6 cycles with address 0; capture one cycle after acceptance; period stretches by 5.
5. event_pending=1, event_clear=1 on the same edge as a new key_fall -> event_pending stays 1; event_clear alone on the next cycle -> 0.
6. Reset pulsed while in WAIT with readdata[0]=0 -> no capture; key_level=1, db_cnt=0, FSM IDLE. With TIMEOUT_EN defined and WAIT_TIMEOUT=8, waitrequest stuck 1 -> avm_read drops after 8 cycles, bus_error=1.
